// File: rtl/adc_scan_scheduler.sv
// Scans NUM_CH adc channel controllers in ascending order over one shared I2C master
// and captures each channel's 16-bit result. Optional watchdog: define SCAN_TIMEOUT_EN.
module adc_scan_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PERIOD_CYCLES  = 27000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   run_i,
  input  logic [NUM_CH-1:0]      chan_mask_i,
  output logic [NUM_CH-1:0]      adc_enable_o,
  input  logic [NUM_CH-1:0]      adc_data_ready_i,
  input  logic [16*NUM_CH-1:0]   adc_data_i,
  input  logic [2*NUM_CH-1:0]    adc_i2c_instruction_i,
  input  logic [NUM_CH-1:0]      adc_i2c_enable_i,
  input  logic [8*NUM_CH-1:0]    adc_i2c_byte_i,
  output logic [1:0]             i2c_instruction_o,
  output logic                   i2c_enable_o,
  output logic [7:0]             i2c_byte_to_send_o,
  output logic [16*NUM_CH-1:0]   result_o,
  output logic [NUM_CH-1:0]      result_valid_o,
  output logic                   scan_done_o,
  output logic                   busy_o,
  output logic [NUM_CH-1:0]      error_o,
  output logic [2:0]             state_o
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ENABLE      = 3'd1,
    WAIT_BUSY   = 3'd2,
    WAIT_DONE   = 3'd3,
    RELEASE     = 3'd4,
    NEXT        = 3'd5,
    WAIT_PERIOD = 3'd6
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  grant_q;
  logic [NUM_CH-1:0] mask_q;
  logic [PER_W-1:0]  per_cnt_q;
  logic [NUM_CH-1:0] start_mask;
  logic [IDX_W:0]    start_sel;
  logic [IDX_W:0]    next_sel;
  logic              per_hit;
  logic              rdy_g;
  int                gi;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [IDX_W:0] first_from(input logic [NUM_CH-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]   wd_q;
  logic              wd_hit;
  logic [NUM_CH-1:0] error_q;

  assign wd_hit     = (32'(wd_q) == (TIMEOUT_CYCLES - 1));
  assign error_o    = error_q;
  assign start_mask = chan_mask_i & ~error_q;

  // Counts the cycles the granted channel has spent in WAIT_BUSY plus WAIT_DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign error_o    = '0;
  assign start_mask = chan_mask_i;
`endif

  assign gi        = 32'(grant_q);
  assign rdy_g     = adc_data_ready_i[grant_q];
  assign start_sel = first_from(start_mask, 0);
  assign next_sel  = first_from(mask_q, gi + 1);
  assign state_o   = state_q;

  // Leaving WAIT_PERIOD on the edge where the counter reaches PERIOD_CYCLES-1 puts the
  // following scan start exactly PERIOD_CYCLES cycles after the previous one.
  assign per_hit = (32'(per_cnt_q) + 32'd1) >= (PERIOD_CYCLES - 1);

  always_comb begin
    i2c_instruction_o  = adc_i2c_instruction_i[2*gi +: 2];
    i2c_byte_to_send_o = adc_i2c_byte_i[8*gi +: 8];
    i2c_enable_o       = 1'b0;
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) i2c_enable_o = adc_i2c_enable_i[grant_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      mask_q         <= '0;
      per_cnt_q      <= '0;
      adc_enable_o   <= '0;
      result_o       <= '0;
      result_valid_o <= '0;
      scan_done_o    <= 1'b0;
      busy_o         <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      error_q        <= '0;
`endif
    end else begin
      scan_done_o <= 1'b0;
      if (per_cnt_q != PER_MAX) per_cnt_q <= per_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (run_i && start_sel[IDX_W]) begin
            mask_q    <= start_mask;
            per_cnt_q <= '0;
            busy_o    <= 1'b1;
            grant_q   <= start_sel[IDX_W-1:0];
            state_q   <= ENABLE;
          end
        end
        ENABLE: begin
          adc_enable_o <= NUM_CH'(1) << grant_q;
          state_q      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A channel still showing ready here has not yet taken the enable.
          if (!rdy_g) begin
            state_q <= WAIT_DONE;
          end
`ifdef SCAN_TIMEOUT_EN
          else if (wd_hit) begin
            error_q[grant_q] <= 1'b1;
            adc_enable_o     <= '0;
            state_q          <= NEXT;
          end
`endif
        end
        WAIT_DONE: begin
          if (rdy_g) begin
            result_o[16*gi +: 16]   <= adc_data_i[16*gi +: 16];
            result_valid_o[grant_q] <= 1'b1;
            adc_enable_o            <= '0;
            state_q                 <= RELEASE;
          end
`ifdef SCAN_TIMEOUT_EN
          else if (wd_hit) begin
            error_q[grant_q] <= 1'b1;
            adc_enable_o     <= '0;
            state_q          <= NEXT;
          end
`endif
        end
        RELEASE: begin
          if (rdy_g) state_q <= NEXT;
        end
        NEXT: begin
          if (next_sel[IDX_W]) begin
            grant_q <= next_sel[IDX_W-1:0];
            state_q <= ENABLE;
          end else begin
            scan_done_o <= 1'b1;
            busy_o      <= 1'b0;
            // An overrun scan goes straight back to IDLE so the next one starts at once.
            state_q     <= (!run_i || per_hit) ? IDLE : WAIT_PERIOD;
          end
        end
        WAIT_PERIOD: begin
          if (!run_i || per_hit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: four behavioural adc channels around one DUT,
// periodic scans, masks, overrun, run drop, mid-scan reset and the optional watchdog.
module tb_adc_scan_scheduler;

  logic        clk;
  logic        rst_ni;
  logic        run_i;
  logic [3:0]  chan_mask_i;
  logic [3:0]  adc_enable_o;
  logic [3:0]  adc_rdy;
  logic [63:0] adc_dat;
  logic [7:0]  adc_ins;
  logic [3:0]  adc_ien;
  logic [31:0] adc_byte;
  logic [1:0]  i2c_instruction_o;
  logic        i2c_enable_o;
  logic [7:0]  i2c_byte_to_send_o;
  logic [63:0] result_o;
  logic [3:0]  result_valid_o;
  logic        scan_done_o;
  logic        busy_o;
  logic [3:0]  error_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  int lat[4];
  bit stuck[4];

  adc_scan_scheduler #(
    .NUM_CH(4), .PERIOD_CYCLES(200), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .chan_mask_i(chan_mask_i),
    .adc_enable_o(adc_enable_o), .adc_data_ready_i(adc_rdy), .adc_data_i(adc_dat),
    .adc_i2c_instruction_i(adc_ins), .adc_i2c_enable_i(adc_ien), .adc_i2c_byte_i(adc_byte),
    .i2c_instruction_o(i2c_instruction_o), .i2c_enable_o(i2c_enable_o),
    .i2c_byte_to_send_o(i2c_byte_to_send_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .scan_done_o(scan_done_o), .busy_o(busy_o),
    .error_o(error_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural channel: ready idles high, drops on enable, keeps its I2C enable up until
  // the scheduler drops enable, and returns 16'h1111*(k+1) after lat[k]+1 busy cycles.
  for (genvar k = 0; k < 4; k++) begin : g_adc
    logic [1:0]  m;
    logic        rdy;
    logic        ien;
    logic [15:0] dat;
    int          cnt;
    always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        m <= 2'd0; rdy <= 1'b1; ien <= 1'b0; dat <= 16'h0; cnt <= 0;
      end else begin
        case (m)
          2'd0: if (adc_enable_o[k]) begin
            m <= 2'd1; rdy <= 1'b0; ien <= 1'b1; cnt <= lat[k]; dat <= 16'h0;
          end
          2'd1: if (!adc_enable_o[k]) begin
            m <= 2'd0; rdy <= 1'b1; ien <= 1'b0;
          end else if (!stuck[k]) begin
            if (cnt == 0) begin
              m <= 2'd2; rdy <= 1'b1; dat <= 16'(16'h1111 * (k + 1));
            end else begin
              cnt <= cnt - 1;
            end
          end
          default: if (!adc_enable_o[k]) begin
            m <= 2'd0; ien <= 1'b0;
          end
        endcase
      end
    end
    assign adc_rdy[k]          = rdy;
    assign adc_ien[k]          = ien;
    assign adc_dat[16*k +: 16] = dat;
    assign adc_ins[2*k +: 2]   = ien ? 2'(k) : 2'b00;
    assign adc_byte[8*k +: 8]  = ien ? (8'hA0 + 8'(k)) : 8'h00;
  end

  // monitors, sampled on the falling edge
  int         cyc = 0;
  int         done_cnt = 0, last_done = 0, prev_done = 0, last_rise = 0;
  int         i2c_cnt = 0, mux_bad = 0, onehot_bad = 0, en_cnt = 0;
  int         i2c_ch[4] = '{0, 0, 0, 0};
  logic [3:0] en_d = '0;
  logic       busy_d = 1'b0;
  logic [2:0] grant_q[$];
  logic [2:0] exp_q[$];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    en_d   <= adc_enable_o;
    busy_d <= busy_o;
    for (int k = 0; k < 4; k++) if (adc_enable_o[k] && !en_d[k]) grant_q.push_back(3'(k));
    if (!$onehot0(adc_enable_o)) onehot_bad <= onehot_bad + 1;
    if (adc_enable_o != 4'b0) en_cnt <= en_cnt + 1;
    if (busy_o && !busy_d) last_rise <= cyc;
    if (scan_done_o) begin
      done_cnt  <= done_cnt + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
    if (i2c_enable_o) begin
      i2c_cnt <= i2c_cnt + 1;
      i2c_ch[i2c_byte_to_send_o[1:0]] <= i2c_ch[i2c_byte_to_send_o[1:0]] + 1;
      if (i2c_instruction_o != i2c_byte_to_send_o[1:0] || i2c_byte_to_send_o[7:2] != 6'b101000)
        mux_bad <= mux_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return scan_done_o === 1'b1;
      1:       return busy_o === 1'b1;
      2:       return adc_enable_o[2] === 1'b1;
      default: return state_o === 3'd3 && adc_enable_o[1] === 1'b1 && i2c_enable_o === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(sel) && n < budget);
    check(tag, 64'(cond(sel)), 64'd1);
  endtask

  task automatic push_grants(input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[k]) exp_q.push_back(3'(k));
  endtask

  task automatic check_grants(input int base, input string tag);
    int n;
    n = exp_q.size();
    check({tag, " count"}, 64'(grant_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check(tag, (base + i < grant_q.size()) ? 64'(grant_q[base + i]) : 64'hFF, 64'(e));
    end
  endtask

  function automatic logic [3:0] seen_mask(input int snap[4]);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k] = (i2c_ch[k] != snap[k]);
    return r;
  endfunction

  task automatic reset_pulse();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    int base, dsnap, isnap, esnap;
    int csnap[4];
    rst_ni = 1'b0; run_i = 1'b0; chan_mask_i = 4'h0;
    for (int k = 0; k < 4; k++) begin lat[k] = 9; stuck[k] = 1'b0; end
    repeat (3) @(negedge clk);

    // reset values
    check("rst adc_enable", 64'(adc_enable_o), 64'h0);
    check("rst i2c_enable", 64'(i2c_enable_o), 64'h0);
    check("rst i2c_instr", 64'(i2c_instruction_o), 64'h0);
    check("rst i2c_byte", 64'(i2c_byte_to_send_o), 64'h0);
    check("rst result", result_o, 64'h0);
    check("rst valid", 64'(result_valid_o), 64'h0);
    check("rst done", 64'(scan_done_o), 64'h0);
    check("rst busy", 64'(busy_o), 64'h0);
    check("rst error", 64'(error_o), 64'h0);
    check("rst state", 64'(state_o), 64'h0);

    // full mask scan
    base = grant_q.size(); dsnap = done_cnt; isnap = i2c_cnt; csnap = i2c_ch;
    push_grants(4'b1111);
    rst_ni = 1'b1; run_i = 1'b1; chan_mask_i = 4'hF;
    wait_for(0, 2000, "A done wait");
    @(negedge clk);
    check_grants(base, "A grant");
    check("A result", result_o, 64'h4444_3333_2222_1111);
    check("A valid", 64'(result_valid_o), 64'hF);
    check("A done pulses", 64'(done_cnt - dsnap), 64'd1);
    check("A i2c cycles", 64'(i2c_cnt - isnap), 64'd44);
    check("A i2c channels", 64'(seen_mask(csnap)), 64'hF);
    check("A busy after", 64'(busy_o), 64'h0);
    run_i = 1'b0;
    repeat (5) @(negedge clk);

    // sparse mask, period spacing, mask change mid-scan ignored
    reset_pulse();
    base = grant_q.size(); isnap = i2c_cnt; csnap = i2c_ch;
    push_grants(4'b1010);
    run_i = 1'b1; chan_mask_i = 4'b1010;
    wait_for(0, 2000, "B done wait");
    @(negedge clk);
    check_grants(base, "B grant");
    check("B valid", 64'(result_valid_o), 64'b1010);
    check("B result", result_o, 64'h4444_0000_2222_0000);
    check("B i2c cycles", 64'(i2c_cnt - isnap), 64'd22);
    check("B i2c channels", 64'(seen_mask(csnap)), 64'b1010);
    wait_for(1, 400, "B2 start wait");
    chan_mask_i = 4'b0101;
    base = grant_q.size();
    push_grants(4'b1010);
    wait_for(0, 400, "B2 done wait");
    @(negedge clk);
    check("B period", 64'(last_done - prev_done), 64'd200);
    check_grants(base, "B2 grant");
    run_i = 1'b0;
    repeat (250) @(negedge clk);

    // overrun: scan longer than the period restarts right after NEXT
    for (int k = 0; k < 4; k++) lat[k] = 60;
    chan_mask_i = 4'hF; run_i = 1'b1;
    wait_for(0, 2000, "C done wait");
    repeat (3) @(negedge clk);
    check("C busy restart", 64'(busy_o), 64'h1);
    check("C restart gap", 64'(last_rise - last_done), 64'd1);
    run_i = 1'b0;
    wait_for(0, 2000, "C2 done wait");
    for (int k = 0; k < 4; k++) lat[k] = 9;

    // run_i drops during channel 2
    reset_pulse();
    base = grant_q.size();
    push_grants(4'b1111);
    run_i = 1'b1; chan_mask_i = 4'hF;
    wait_for(2, 2000, "D ch2 wait");
    run_i = 1'b0;
    wait_for(0, 2000, "D done wait");
    @(negedge clk);
    dsnap = done_cnt; esnap = en_cnt;
    check_grants(base, "D grant");
    check("D valid", 64'(result_valid_o), 64'hF);
    check("D ch3 result", 64'(result_o[63:48]), 64'h4444);
    repeat (300) @(negedge clk);
    check("D no more done", 64'(done_cnt - dsnap), 64'd0);
    check("D enable quiet", 64'(en_cnt - esnap), 64'd0);
    check("D state idle", 64'(state_o), 64'h0);
    check("D busy", 64'(busy_o), 64'h0);

    // reset while channel 1 is mid-conversion
    reset_pulse();
    run_i = 1'b1; chan_mask_i = 4'hF;
    wait_for(3, 2000, "E ch1 wait");
    rst_ni = 1'b0;
    #1;
    check("E adc_enable", 64'(adc_enable_o), 64'h0);
    check("E i2c_enable", 64'(i2c_enable_o), 64'h0);
    check("E busy", 64'(busy_o), 64'h0);
    check("E valid", 64'(result_valid_o), 64'h0);
    check("E result", result_o, 64'h0);
    check("E state", 64'(state_o), 64'h0);
    repeat (2) @(negedge clk);
    base = grant_q.size();
    push_grants(4'b1111);
    rst_ni = 1'b1;
    wait_for(0, 2000, "E done wait");
    @(negedge clk);
    check_grants(base, "E grant");
    check("E one-hot", 64'(onehot_bad), 64'd0);
    check("E i2c mux", 64'(mux_bad), 64'd0);

`ifdef SCAN_TIMEOUT_EN
    // watchdog: channel 2 never finishes
    run_i = 1'b0;
    repeat (2) @(negedge clk);
    stuck[2] = 1'b1;
    reset_pulse();
    base = grant_q.size();
    push_grants(4'b1111);
    run_i = 1'b1; chan_mask_i = 4'hF;
    wait_for(0, 2000, "F done wait");
    @(negedge clk);
    check_grants(base, "F grant");
    check("F error", 64'(error_o), 64'b0100);
    check("F result", result_o, 64'h4444_0000_2222_1111);
    check("F valid", 64'(result_valid_o), 64'b1011);
    base = grant_q.size();
    push_grants(4'b1011);
    wait_for(0, 400, "F2 done wait");
    @(negedge clk);
    check_grants(base, "F2 grant");
    check("F2 error", 64'(error_o), 64'b0100);
`else
    check("no watchdog error", 64'(error_o), 64'h0);
`endif

    run_i = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
